// File: rtl/double_buffer_from_dally_harting.sv
// ---------------------------------------------------------------------------
// double_buffer_from_dally_harting
// Two-entry strict-FIFO elastic buffer on a valid/ready stream.
// up_ready is a function of the occupancy only, so it never depends
// combinationally on down_ready. This breaks the ready path between the
// producer and the consumer.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (empties the buffer)
//   up_valid   producer data valid
//   up_ready   buffer can accept (occupancy != 2)
//   up_data    producer data
//   down_valid buffer holds at least one entry
//   down_ready consumer ready
//   down_data  head entry, stable while down_valid & !down_ready
// ---------------------------------------------------------------------------
module double_buffer_from_dally_harting #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [width-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [width-1:0] down_data
);

    logic [1:0]       count;
    logic [width-1:0] head_q;
    logic [width-1:0] tail_q;
    logic             push;
    logic             pop;

    assign up_ready   = (count != 2'd2);
    assign down_valid = (count != 2'd0);
    assign down_data  = head_q;
    assign push       = up_valid & up_ready;
    assign pop        = down_valid & down_ready;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
        end else if (push && !pop) begin
            count <= count + 2'd1;
        end else if (pop && !push) begin
            count <= count - 2'd1;
        end
    end

    // NOTE: the data registers are deliberately not reset. They are only
    // observed through down_valid, which the reset of count already clears.
    always_ff @(posedge clk) begin
        case (count)
            2'd0: if (push) head_q <= up_data;
            2'd1: begin
                if (push && pop) head_q <= up_data;
                else if (push)   tail_q <= up_data;
            end
            2'd2: if (pop) head_q <= tail_q;
            default: ;
        endcase
    end

endmodule

// File: rtl/shared_adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// shared_adder_rr_arbiter
// Shares one adder among n_req valid/ready operand streams. A round-robin
// arbiter grants at most one requester per cycle. The granted (a + b) mod
// 2^width is tagged with the requester index and pushed into a 2-entry FIFO.
// That FIFO drives a single valid/ready result stream.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (flushes results, pointer = 0)
//   req_valid  per-requester operand valid              [n_req]
//   req_ready  per-requester operand accepted           [n_req]
//   req_a      operand a, requester i at [i*width +: width]
//   req_b      operand b, same packing
//   sum_valid  result valid
//   sum_ready  consumer ready
//   sum_data   a + b of the granted requester (carry dropped)
//   sum_id     index of the requester that produced sum_data
// ---------------------------------------------------------------------------
module shared_adder_rr_arbiter #(
    parameter  int width = 8,
    parameter  int n_req = 4,
    localparam int id_w  = $clog2(n_req)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [n_req-1:0]       req_valid,
    output logic [n_req-1:0]       req_ready,
    input  logic [n_req*width-1:0] req_a,
    input  logic [n_req*width-1:0] req_b,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic [width-1:0]       sum_data,
    output logic [id_w-1:0]        sum_id
);

    logic [id_w-1:0]       ptr;
    logic [id_w-1:0]       grant_id;
    logic                  grant_found;
    logic                  buf_ready;
    logic                  transfer;
    logic [width-1:0]      grant_sum;
    logic [width+id_w-1:0] buf_in;
    logic [width+id_w-1:0] buf_out;
    int                    idx;

    // Search from the pointer upward and wrap. The first valid requester wins.
    // NOTE: every combinational output gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < n_req; k++) begin
            idx = (int'(ptr) + k) % n_req;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = id_w'(idx);
            end
        end
    end

    // buf_ready depends only on the buffer occupancy, so req_ready has no
    // combinational path from sum_ready.
    always_comb begin
        req_ready = '0;
        if (grant_found && buf_ready) req_ready[grant_id] = 1'b1;
    end

    assign transfer  = grant_found & buf_ready;
    assign grant_sum = req_a[int'(grant_id)*width +: width]
                     + req_b[int'(grant_id)*width +: width];
    assign buf_in    = {grant_id, grant_sum};

    // The pointer moves past the winner only when a transfer happens.
    // Otherwise it holds, including while the buffer is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (int'(grant_id) == n_req - 1) ? '0 : grant_id + 1'b1;
        end
    end

    double_buffer_from_dally_harting #(
        .width(width + id_w)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (grant_found),
        .up_ready  (buf_ready),
        .up_data   (buf_in),
        .down_valid(sum_valid),
        .down_ready(sum_ready),
        .down_data (buf_out)
    );

    assign sum_id   = buf_out[width+id_w-1:width];
    assign sum_data = buf_out[width-1:0];

endmodule

// File: tb/tb_shared_adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_adder_rr_arbiter
// Self-checking bench for shared_adder_rr_arbiter. The reference model keeps
// a round-robin pointer as an integer and a queue of expected {id, sum}
// results.
// ---------------------------------------------------------------------------
module tb_shared_adder_rr_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           sum_valid;
    logic           sum_ready;
    logic [W-1:0]   sum_data;
    logic [IW-1:0]  sum_id;

    shared_adder_rr_arbiter #(.width(W), .n_req(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .sum_data (sum_data),
        .sum_id   (sum_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
    } result_t;

    result_t exp_q[$];
    int      m_ptr;
    int      last_g;
    int      last_push;
    int      n_checks;
    int      n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge. It drives one cycle of inputs, checks the outputs
    // against the model, advances the model across the coming posedge, and
    // returns at the following negedge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] a,
                         input logic [N*W-1:0] b, input logic sr);
        logic [N-1:0] exp_ready;
        int           g;
        int           ai;
        int           bi;
        logic [N*W-1:0] av;
        logic [N*W-1:0] bv;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        sum_ready = sr;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        exp_ready = '0;
        if (g >= 0 && exp_q.size() < 2) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("sum_valid", 32'(sum_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("sum_data", 32'(sum_data), exp_q[0].data);
            check("sum_id", 32'(sum_id), exp_q[0].id);
        end
        if (exp_q.size() != 0 && sr) void'(exp_q.pop_front());
        last_g    = g;
        last_push = (exp_ready != '0) ? 1 : 0;
        if (last_push != 0) begin
            av = a >> (g * W);
            bv = b >> (g * W);
            ai = int'(av[W-1:0]);
            bi = int'(bv[W-1:0]);
            exp_q.push_back('{id: g, data: (ai + bi) % (1 << W)});
            m_ptr = (g + 1) % N;
        end
        @(negedge clk);
    endtask

    // Reset for one edge with the current inputs held, then clear the model.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_ptr = 0;
    endtask

    function automatic logic [N*W-1:0] rand_ops();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    logic [N*W-1:0] a_idx;
    logic [N*W-1:0] b_ten;
    logic [N*W-1:0] a2;
    logic [N*W-1:0] b2;
    int             pushes;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_ptr     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        sum_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_idx[i*W +: W] = W'(i);
            b_ten[i*W +: W] = W'(10);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset, then the first grant goes to requester 0.
        cycle('0, '0, '0, 1'b1);
        cycle('1, a_idx, b_ten, 1'b1);
        check("first_grant", 32'(last_g), 0);
        cycle('0, '0, '0, 1'b1);
        cycle('0, '0, '0, 1'b1);

        // 2: a single requester with a wrapping sum. The pointer goes 1 -> 3.
        a2 = '0;
        b2 = '0;
        a2[2*W +: W] = 8'd200;
        b2[2*W +: W] = 8'd100;
        cycle(4'b0100, a2, b2, 1'b1);
        check("wrap_sum", 32'(sum_data), 44);
        check("wrap_id", 32'(sum_id), 2);
        cycle('1, a_idx, b_ten, 1'b1);
        check("ptr_after_2", 32'(last_g), 3);
        cycle('0, '0, '0, 1'b1);
        cycle('0, '0, '0, 1'b1);

        // 3: every requester valid, full throughput, fair rotation.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle('1, a_idx, b_ten, 1'b1);
            check("rr_order", 32'(last_g), 32'(k % N));
            check("rr_push", 32'(last_push), 1);
        end
        repeat (2) cycle('0, '0, '0, 1'b1);

        // 4: a stalled consumer takes exactly two transfers, then drains in order.
        do_reset();
        pushes = 0;
        for (int k = 0; k < 5; k++) begin
            cycle('1, a_idx, b_ten, 1'b0);
            pushes += last_push;
        end
        check("stall_pushes", 32'(pushes), 2);
        cycle('1, a_idx, b_ten, 1'b1);
        check("full_no_push", 32'(last_push), 0);
        cycle('1, a_idx, b_ten, 1'b1);
        check("grant_after_drain", 32'(last_g), 2);
        repeat (3) cycle('0, '0, '0, 1'b1);

        // 5: alternating backpressure with requester 1 always valid.
        do_reset();
        for (int k = 0; k < 30; k++) cycle(4'b0010, rand_ops(), rand_ops(), k[0]);
        repeat (3) cycle('0, '0, '0, 1'b1);

        // 6: a reset with a full buffer flushes it. Traffic restarts at requester 0.
        for (int k = 0; k < 4; k++) cycle('1, a_idx, b_ten, 1'b0);
        do_reset();
        check("flush_valid", 32'(sum_valid), 0);
        cycle('1, a_idx, b_ten, 1'b1);
        check("restart_grant", 32'(last_g), 0);

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            cycle(N'($urandom), rand_ops(), rand_ops(), ($urandom_range(0, 3) != 0));
        end
        repeat (3) cycle('0, '0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shared_adder_rr_arbiter.md
Name: shared_adder_rr_arbiter

Overview:
Shares one adder between n_req independent requesters. Each requester offers an (a, b) operand pair over valid/ready. A round-robin arbiter picks one requester per cycle and computes a + b. The result, tagged with the requester index, goes into a 2-entry output buffer that drives a single valid/ready result stream. The block sits between several producer streams and one downstream consumer of sums.

Parameters:
- width, 8, operand and sum width in bits
- n_req, 4, number of requesters (≥2)
- id_w, $clog2(n_req), width of the requester tag (derived, not overridden)

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- req_valid  input  n_req  per-requester operand valid
- req_ready  output  n_req  per-requester operand accepted
- req_a  input  n_req*width  operand a; requester i occupies bits [i*width +: width]
- req_b  input  n_req*width  operand b, same packing as req_a
- sum_valid  output  1  result valid
- sum_ready  input  1  consumer ready
- sum_data  output  width  a + b of the granted requester
- sum_id  output  id_w  index of the requester that produced sum_data

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. rst is synchronous and active-high.
- Reset:
  - Output buffer becomes empty; sum_valid = 0.
  - Round-robin pointer = 0.
  - sum_data and sum_id are don't-care while sum_valid = 0.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i] = 1, searching from the pointer upward and wrapping modulo n_req.
  - At most one grant per cycle.
- Ready:
  - req_ready[i] = grant[i] & buf_not_full.
  - Non-granted requesters see req_ready = 0.
  - req_ready may depend combinationally on req_valid.
  - req_ready must NOT depend combinationally on sum_ready.
- Transfer on requester i: req_valid[i] & req_ready[i] at a clock edge.
  - The entry {id = i, data = (a_i + b_i) mod 2^width} is pushed into the buffer; the carry is discarded.
  - The pointer becomes (i + 1) mod n_req.
- Pointer rules:
  - The pointer is unchanged in any cycle without a transfer.
  - It is unchanged when the buffer is full, even if requests are pending.
- Output buffer: 2 entries, strict FIFO order.
  - buf_not_full = (count != 2).
  - sum_valid = (count != 0); sum_data and sum_id come from the head entry.
  - Pop occurs on sum_valid & sum_ready.
  - Push and pop in the same cycle: count is unchanged, order is preserved.
  - At count = 2 a push is impossible, because req_ready = 0.
  - sum_data and sum_id must hold stable while sum_valid = 1 and sum_ready = 0.
- Latency and throughput:
  - A transfer at edge k makes the result visible no earlier than the cycle after edge k (1 cycle when the buffer is empty).
  - Sustained throughput is 1 result per cycle while sum_ready = 1.
- Fairness: with all requesters continuously valid and sum_ready = 1, grants cycle 0, 1, …, n_req-1, 0, …
- Boundary conditions:
  - A requester may drop req_valid without a transfer; no state is affected.
  - Operands are sampled only at the transfer edge.
  - rst asserted mid-operation flushes both buffer entries; buffered results are lost.
  - On the cycle after reset, sum_valid = 0.

Decomposition:
- Shared package: none needed. id_w is a localparam inside the block.
- Sub-module: the 2-entry buffer, reusing the team's existing double_buffer_from_dally_harting with width = width + id_w. Its up_ready depends only on its internal state.
- Arbiter priority logic stays inline.

Test Plan:
1. Reset, then idle → sum_valid = 0 and req_ready = 0 for all requesters; after requesters become valid, the first grant goes to requester 0.
2. Only req 2 valid with a = 8'd200, b = 8'd100, sum_ready = 1 → one transfer; next cycle sum_valid = 1, sum_data = 8'd44 (wrap), sum_id = 2; the pointer becomes 3.
3. All 4 requesters valid continuously, req i has a = i, b = 10, sum_ready = 1 → sum_id sequence 0,1,2,3,0,…; sum_data = 10,11,12,13,10; one result per cycle.
4. All requesters valid, sum_ready = 0 → exactly 2 transfers (ids 0, 1), then all req_ready = 0 with the pointer held at 2. Raise sum_ready → results 0, 1 drain in order, then id 2 is granted.
5. Backpressure toggling: sum_ready alternates 1/0 with req 1 constantly valid → sum_data/sum_id stable during stall cycles, no loss or duplication; a scoreboard matches every accepted operand pair in order.
6. rst asserted while the buffer holds 2 entries → the following cycle has sum_valid = 0, the pointer is 0, and subsequent traffic starts at requester 0.
